// File: rtl/conv_ctrl_pkg.sv
// Shared types and width helpers for the conv_3 lane-array scheduler.
package conv_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KERNEL,
        STREAM,
        DRAIN,
        DONE
    } state_e;

    // Index widths never drop below one bit so degenerate sizes still elaborate.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int kcol_w(input int kernel_size);
        return clog2_min1(kernel_size);
    endfunction

    function automatic int col_w(input int image_size);
        return clog2_min1(image_size);
    endfunction

    function automatic int kidx_w(input int num_kernels);
        return clog2_min1(num_kernels);
    endfunction

    function automatic int cred_w(input int fifo_depth);
        return clog2_min1(fifo_depth + 1);
    endfunction

endpackage

// File: rtl/conv_tag_pipe.sv
// Delay line carrying {valid, kidx, col} alongside the lane pipeline so the
// tags line up with the lane results.
module conv_tag_pipe
    import conv_ctrl_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int KIDX_W = 2,
    parameter int COL_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_i,
    input  logic [KIDX_W-1:0] kidx_i,
    input  logic [COL_W-1:0]  col_i,
    output logic              valid_o,
    output logic [KIDX_W-1:0] kidx_o,
    output logic [COL_W-1:0]  col_o,
    output logic              empty
);

    logic [DEPTH-1:0]  valid_q;
    logic [KIDX_W-1:0] kidx_q [DEPTH];
    logic [COL_W-1:0]  col_q  [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kidx_q[i] <= '0;
                col_q[i]  <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            kidx_q[0]  <= kidx_i;
            col_q[0]   <= col_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                kidx_q[i]  <= kidx_q[i-1];
                col_q[i]   <= col_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign kidx_o  = kidx_q[DEPTH-1];
    assign col_o   = col_q[DEPTH-1];

    // The entry currently presented on the output does not count: the
    // scheduler may leave DRAIN in the same cycle as the last result.
    generate
        if (DEPTH > 1) begin : g_empty_multi
            assign empty = ~|valid_q[DEPTH-2:0];
        end else begin : g_empty_single
            assign empty = 1'b1;
        end
    endgenerate

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Sequences kernel loads and column streaming for the conv_3 lane array,
// tags lane results and throttles result-producing issues on FIFO credits.
module conv_kernel_scheduler
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int KERNEL_SIZE    = 3,
    parameter int IMAGE_SIZE     = 12,
    parameter int NUM_KERNELS    = 4,
    parameter int PIPE_LAT       = 2,
    parameter int OUT_FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    output logic                                busy,
    output logic                                done,
    output logic                                kern_rd_en,
    output logic [kidx_w(NUM_KERNELS)-1:0]      kern_rd_kidx,
    output logic [kcol_w(KERNEL_SIZE)-1:0]      kern_rd_col,
    output logic                                img_rd_en,
    output logic [col_w(IMAGE_SIZE)-1:0]        img_rd_col,
    output logic                                lane_kernel_load,
    output logic                                lane_valid_in,
    output logic                                out_valid,
    output logic [kidx_w(NUM_KERNELS)-1:0]      out_kidx,
    output logic [col_w(IMAGE_SIZE)-1:0]        out_col,
    input  logic                                out_pop
);

    localparam int KCOL_W = kcol_w(KERNEL_SIZE);
    localparam int COL_W  = col_w(IMAGE_SIZE);
    localparam int KIDX_W = kidx_w(NUM_KERNELS);
    localparam int CRED_W = cred_w(OUT_FIFO_DEPTH);

    localparam logic [KCOL_W-1:0] KCOL_LAST = KCOL_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0]  COL_WARM  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMAGE_SIZE - 1);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(NUM_KERNELS - 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(OUT_FIFO_DEPTH);

    // The lane data path never passes through here; DATA_WIDTH is only sanity-checked.
    generate
        if (DATA_WIDTH < 1 || KERNEL_SIZE < 2 || IMAGE_SIZE < KERNEL_SIZE ||
            NUM_KERNELS < 1 || PIPE_LAT < 0 || OUT_FIFO_DEPTH < 1) begin : g_param_check
            $error("conv_kernel_scheduler: illegal parameter combination");
        end
    endgenerate

    state_e            state_q, state_d;
    logic [KIDX_W-1:0] kidx_q, kidx_d;
    logic [KCOL_W-1:0] kcol_q, kcol_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [CRED_W-1:0] cred_q, cred_d;
    logic              lane_kernel_load_q, lane_valid_in_q;
    logic              issue_result;
    logic              pipe_empty;

    always_comb begin
        state_d      = state_q;
        kidx_d       = kidx_q;
        kcol_d       = kcol_q;
        col_d        = col_q;
        kern_rd_en   = 1'b0;
        img_rd_en    = 1'b0;
        issue_result = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    kidx_d  = '0;
                    kcol_d  = '0;
                    state_d = LOAD_KERNEL;
                end
            end
            LOAD_KERNEL: begin
                kern_rd_en = 1'b1;
                kcol_d     = kcol_q + 1'b1;
                if (kcol_q == KCOL_LAST) begin
                    col_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // Warm-up columns only prime the window and need no FIFO slot.
                if (col_q < COL_WARM || cred_q != '0) begin
                    img_rd_en    = 1'b1;
                    issue_result = (col_q >= COL_WARM);
                    col_d        = col_q + 1'b1;
                    if (col_q == COL_LAST) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    if (kidx_q != KIDX_LAST) begin
                        kidx_d  = kidx_q + 1'b1;
                        kcol_d  = '0;
                        state_d = LOAD_KERNEL;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        cred_d = cred_q;
        if (issue_result && !out_pop) begin
            cred_d = cred_q - 1'b1;
        end else if (!issue_result && out_pop && cred_q != CRED_MAX) begin
            cred_d = cred_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            kidx_q             <= '0;
            kcol_q             <= '0;
            col_q              <= '0;
            cred_q             <= CRED_MAX;
            lane_kernel_load_q <= 1'b0;
            lane_valid_in_q    <= 1'b0;
        end else begin
            state_q            <= state_d;
            kidx_q             <= kidx_d;
            kcol_q             <= kcol_d;
            col_q              <= col_d;
            cred_q             <= cred_d;
            lane_kernel_load_q <= kern_rd_en;
            lane_valid_in_q    <= img_rd_en;
        end
    end

    conv_tag_pipe #(
        .DEPTH  (PIPE_LAT + 1),
        .KIDX_W (KIDX_W),
        .COL_W  (COL_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (issue_result),
        .kidx_i  (kidx_q),
        .col_i   (col_q - COL_WARM),
        .valid_o (out_valid),
        .kidx_o  (out_kidx),
        .col_o   (out_col),
        .empty   (pipe_empty)
    );

    // Addresses are forced to zero when idle so the memory ports stay quiet.
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign kern_rd_kidx     = kern_rd_en ? kidx_q : '0;
    assign kern_rd_col      = kern_rd_en ? kcol_q : '0;
    assign img_rd_col       = img_rd_en ? col_q : '0;
    assign lane_kernel_load = lane_kernel_load_q;
    assign lane_valid_in    = lane_valid_in_q;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Bench for conv_kernel_scheduler: cycle-table checks of a full job, a tag
// scoreboard, credit stall / pop corner cases and mid-job reset.
module tb_conv_kernel_scheduler;

    localparam int KS    = 3;
    localparam int IS    = 12;
    localparam int NK    = 4;
    localparam int PL    = 2;
    localparam int DEPTH = 8;
    localparam int PER_K = KS + IS + 1 + PL;
    localparam int NV    = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       out_pop;
    logic       busy, done, kern_rd_en, img_rd_en;
    logic       lane_kernel_load, lane_valid_in, out_valid;
    logic [1:0] kern_rd_kidx, kern_rd_col, out_kidx;
    logic [3:0] img_rd_col, out_col;

    logic auto_pop = 1'b1;
    logic man_pop  = 1'b0;

    int total   = 0;
    int bad     = 0;
    int cyc_abs = 0;
    int ov_cnt  = 0;
    int lvi_cnt = 0;
    logic lkl_prev = 1'b0;

    typedef struct {
        int kidx;
        int col;
        int cyc;
    } sb_t;
    sb_t exp_q[$];

    typedef struct {
        int cyc;
        int busy, done, kre, ire, lkl, lvi;
        int kidx, kcol, icol;
    } vec_t;
    vec_t vecs[NV];

    conv_kernel_scheduler #(
        .DATA_WIDTH     (16),
        .KERNEL_SIZE    (KS),
        .IMAGE_SIZE     (IS),
        .NUM_KERNELS    (NK),
        .PIPE_LAT       (PL),
        .OUT_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .kern_rd_en       (kern_rd_en),
        .kern_rd_kidx     (kern_rd_kidx),
        .kern_rd_col      (kern_rd_col),
        .img_rd_en        (img_rd_en),
        .img_rd_col       (img_rd_col),
        .lane_kernel_load (lane_kernel_load),
        .lane_valid_in    (lane_valid_in),
        .out_valid        (out_valid),
        .out_kidx         (out_kidx),
        .out_col          (out_col),
        .out_pop          (out_pop)
    );

    always #5 clk = ~clk;

    always_comb out_pop = auto_pop ? out_valid : man_pop;

    initial forever begin
        @(posedge clk);
        cyc_abs++;
    end

    function automatic void chk(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp_v, cyc_abs);
        end
    endfunction

    function automatic int all_outputs();
        return int'({busy, done, kern_rd_en, kern_rd_kidx, kern_rd_col, img_rd_en,
                     img_rd_col, lane_kernel_load, lane_valid_in, out_valid, out_kidx, out_col});
    endfunction

    // Monitor: lane control overlap, per-kernel column count and the tag scoreboard.
    initial forever begin
        @(negedge clk);
        total++;
        assert (!(lane_kernel_load && lane_valid_in)) else begin
            bad++;
            $display("FAIL lane_overlap: kernel_load=1 valid_in=1, want never both (cycle %0d)", cyc_abs);
        end
        if (rst) begin
            lvi_cnt = 0;
        end else begin
            if (lane_kernel_load && !lkl_prev) begin
                if (lvi_cnt != 0) chk("lvi_per_kernel", lvi_cnt, IS);
                lvi_cnt = 0;
            end
            if (lane_valid_in) lvi_cnt++;
            if (done) begin
                chk("lvi_last_kernel", lvi_cnt, IS);
                lvi_cnt = 0;
            end
        end
        lkl_prev = lane_kernel_load;
        if (out_valid) begin
            ov_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", int'(out_valid), 0);
            end else begin
                sb_t e;
                e = exp_q.pop_front();
                $display("out: kidx=%0d col=%0d cycle=%0d (want kidx=%0d col=%0d cycle=%0d)",
                         out_kidx, out_col, cyc_abs, e.kidx, e.col, e.cyc);
                chk("out_kidx", int'(out_kidx), e.kidx);
                chk("out_col", int'(out_col), e.col);
                if (e.cyc >= 0) chk("out_cycle", cyc_abs, e.cyc);
            end
        end
    end

    task automatic push_job(input int base);
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c <= IS - KS; c++) begin
                exp_q.push_back('{k, c, base + 1 + PER_K * k + 2 * KS + PL + c});
            end
        end
    endtask

    task automatic check_vec(input int vi);
        chk("vec_busy", int'(busy), vecs[vi].busy);
        chk("vec_done", int'(done), vecs[vi].done);
        chk("vec_kern_rd_en", int'(kern_rd_en), vecs[vi].kre);
        chk("vec_img_rd_en", int'(img_rd_en), vecs[vi].ire);
        chk("vec_lane_kernel_load", int'(lane_kernel_load), vecs[vi].lkl);
        chk("vec_lane_valid_in", int'(lane_valid_in), vecs[vi].lvi);
        if (vecs[vi].kre != 0) begin
            chk("vec_kern_rd_kidx", int'(kern_rd_kidx), vecs[vi].kidx);
            chk("vec_kern_rd_col", int'(kern_rd_col), vecs[vi].kcol);
        end
        if (vecs[vi].ire != 0) chk("vec_img_rd_col", int'(img_rd_col), vecs[vi].icol);
    endtask

    task automatic wait_done(input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen == 0; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
    endtask

    // Full job with consumer popping every result; optional ignored start
    // pulses while busy and start held through DONE to relaunch.
    task automatic run_table_job(input int pulses, input int hold);
        int n  = cyc_abs;
        int vi = 0;
        push_job(n);
        for (int rel = 0; rel <= 74; rel++) begin
            if (vi < NV && vecs[vi].cyc == rel) begin
                check_vec(vi);
                vi++;
            end
            if (rel == 0) start = 1'b1;
            else if (hold != 0 && rel >= 72) start = 1'b1;
            else if (pulses != 0 && (rel == 10 || rel == 40)) start = 1'b1;
            else start = 1'b0;
            @(negedge clk);
        end
        if (hold != 0) begin
            chk("relaunch_busy", int'(busy), 1);
            chk("relaunch_kern_rd_en", int'(kern_rd_en), 1);
            start = 1'b0;
            push_job(n + 74);
            wait_done(100);
            @(negedge clk);
            chk("relaunch_busy_after", int'(busy), 0);
        end
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("reset_outputs_zero", all_outputs(), 0);
        rst = 1'b0;
    endtask

    initial begin
        int n, iss, ov0;
        vecs[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,  1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{2,  1, 0, 1, 0, 1, 0, 0, 1, 0};
        vecs[3]  = '{3,  1, 0, 1, 0, 1, 0, 0, 2, 0};
        vecs[4]  = '{4,  1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[5]  = '{5,  1, 0, 0, 1, 0, 1, 0, 0, 1};
        vecs[6]  = '{15, 1, 0, 0, 1, 0, 1, 0, 0, 11};
        vecs[7]  = '{16, 1, 0, 0, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{17, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[9]  = '{19, 1, 0, 1, 0, 0, 0, 1, 0, 0};
        vecs[10] = '{22, 1, 0, 0, 1, 1, 0, 0, 0, 0};
        vecs[11] = '{55, 1, 0, 1, 0, 0, 0, 3, 0, 0};
        vecs[12] = '{69, 1, 0, 0, 1, 0, 1, 0, 0, 11};
        vecs[13] = '{72, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{73, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        vecs[15] = '{74, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state_zero", all_outputs(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Unstalled job with plentiful credits.
        run_table_job(0, 0);

        // No pops: stall after DEPTH result issues.
        auto_pop = 1'b0;
        man_pop  = 1'b0;
        n   = cyc_abs;
        ov0 = ov_cnt;
        for (int c = 0; c < DEPTH; c++) exp_q.push_back('{0, c, n + 1 + 2 * KS + PL + c});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        iss = 0;
        for (int rel = 1; rel < 30; rel++) begin
            if (rel >= 14 && img_rd_en) iss++;
            @(negedge clk);
        end
        chk("stall_busy", int'(busy), 1);
        chk("stall_no_issue", iss, 0);
        chk("stall_out_count", ov_cnt - ov0, DEPTH);

        // A single pop releases exactly one issue.
        exp_q.push_back('{0, DEPTH, -1});
        man_pop = 1'b1;
        @(negedge clk);
        man_pop = 1'b0;
        iss = 0;
        for (int i = 0; i < 20; i++) begin
            if (img_rd_en) iss++;
            @(negedge clk);
        end
        chk("one_pop_one_issue", iss, 1);
        chk("one_pop_scoreboard", exp_q.size(), 0);

        // Pop coincident with an issue at credits=1 leaves credits at 1.
        exp_q.push_back('{0, IS - KS, -1});
        exp_q.push_back('{1, 0, -1});
        man_pop = 1'b1;
        @(negedge clk);
        chk("coincident_issue_en", int'(img_rd_en), 1);
        chk("coincident_issue_col", int'(img_rd_col), IS - 1);
        iss = 1;
        @(negedge clk);
        man_pop = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (img_rd_en) iss++;
            @(negedge clk);
        end
        chk("coincident_issue_count", iss, 4);
        chk("coincident_scoreboard", exp_q.size(), 0);
        pulse_reset();
        @(negedge clk);

        // Reset during STREAM discards in-flight tags.
        auto_pop = 1'b1;
        n = cyc_abs;
        for (int c = 0; c < 5; c++) exp_q.push_back('{0, c, n + 1 + 2 * KS + PL + c});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        pulse_reset();
        ov0 = ov_cnt;
        repeat (20) @(negedge clk);
        chk("post_reset_no_out_valid", ov_cnt - ov0, 0);
        chk("post_reset_busy", int'(busy), 0);
        chk("post_reset_scoreboard", exp_q.size(), 0);

        // Start pulses while busy are ignored; start held through DONE relaunches.
        run_table_job(1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want test end");
        $fatal(1, "watchdog");
    end

endmodule
